// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master read arbiter: AXI response codes
// (also used by the icache and LSU), controller state encoding, master
// identifiers and the response beat bundle.
package axi_rd_arbiter_pkg;

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Master identifiers, also used as the owner / last-grant encoding
  localparam logic OWNER_ICACHE = 1'b0;
  localparam logic OWNER_LSU    = 1'b1;

  // One read response beat as routed back to a master
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rbeat_t;

  // One-hot request/grant mask for a master identifier
  function automatic logic [1:0] owner_mask(input logic who);
    return who ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker. A lone request always
// wins; on a tie the requester that was not granted last wins.
module rr_pick2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick a single winner (one-hot) or nobody when there is no request
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = owner_mask(~last);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (icache, LSU) single-slave read-channel arbiter. One single-beat
// read is in flight at a time. A watchdog in the data phase synthesizes a
// DECERR so a hung memory cannot wedge either master; the late beat, if it
// ever shows up, is absorbed before the next request is granted.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        icache_arvalid_i,
  input  logic [31:0] icache_araddr_i,
  output logic        icache_arready_o,
  output logic        icache_rvalid_o,
  output logic [31:0] icache_rdata_o,
  output logic [1:0]  icache_rresp_o,
  input  logic        icache_rready_i,

  input  logic        lsu_arvalid_i,
  input  logic [31:0] lsu_araddr_i,
  output logic        lsu_arready_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic [1:0]  lsu_rresp_o,
  input  logic        lsu_rready_i,

  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  output logic        mem_rready_o,

  output logic        busy_o
);

  // Watchdog counter width; kept at least one bit when the watchdog is off
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [31:0]   addr_q, addr_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          late_seen_q, late_seen_d;

  logic [1:0]    gnt;
  logic          grant_ok;
  logic          owner_rready;
  logic          rsp_valid;
  rbeat_t        rsp_beat;

  rr_pick2 u_pick (
    .req  ({lsu_arvalid_i, icache_arvalid_i}),
    .last (last_grant_q),
    .gnt  (gnt)
  );

  // Grants only happen in IDLE and never while reset is held, so arready
  // is guaranteed low during reset even if a master is already requesting
  assign grant_ok         = (state_q == ST_IDLE) && reset;
  assign icache_arready_o = grant_ok && gnt[0];
  assign lsu_arready_o    = grant_ok && gnt[1];
  assign owner_rready     = (owner_q == OWNER_LSU) ? lsu_rready_i : icache_rready_i;
  assign busy_o           = (state_q != ST_IDLE);

  // Next-state logic: arbitration, address phase, data phase with watchdog,
  // synthesized error and draining of a late memory beat
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    tmo_cnt_d    = tmo_cnt_q;
    late_seen_d  = late_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d      = gnt[1];
          last_grant_d = gnt[1];
          addr_d       = gnt[1] ? lsu_araddr_i : icache_araddr_i;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mem_arready_i) begin
          tmo_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_rvalid_i && owner_rready) begin
          state_d = ST_IDLE;
        end else if (WDOG_EN && (tmo_cnt_q == TMO_LAST) && !mem_rvalid_i) begin
          late_seen_d = 1'b0;
          state_d     = ST_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_ERR: begin
        if (mem_rvalid_i) begin
          late_seen_d = 1'b1;
        end
        if (owner_rready) begin
          state_d = (late_seen_q || mem_rvalid_i) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Downstream drive and the response beat presented to the owner
  always_comb begin
    mem_arvalid_o = 1'b0;
    mem_araddr_o  = '0;
    mem_rready_o  = 1'b0;
    rsp_valid     = 1'b0;
    rsp_beat      = '0;
    case (state_q)
      ST_ADDR: begin
        mem_arvalid_o = 1'b1;
        mem_araddr_o  = addr_q;
      end
      ST_DATA: begin
        rsp_valid     = mem_rvalid_i;
        rsp_beat.data = mem_rdata_i;
        rsp_beat.resp = mem_rresp_i;
        mem_rready_o  = owner_rready;
      end
      ST_ERR: begin
        rsp_valid     = 1'b1;
        rsp_beat.data = '0;
        rsp_beat.resp = RESP_DECERR;
        mem_rready_o  = 1'b1;
      end
      ST_DRAIN: begin
        mem_rready_o = 1'b1;
      end
      default: begin
        mem_rready_o = 1'b0;
      end
    endcase
  end

  // Route the response beat to the owning master; the other master sees zeros
  always_comb begin
    icache_rvalid_o = 1'b0;
    icache_rdata_o  = '0;
    icache_rresp_o  = '0;
    lsu_rvalid_o    = 1'b0;
    lsu_rdata_o     = '0;
    lsu_rresp_o     = '0;
    if (owner_q == OWNER_LSU) begin
      lsu_rvalid_o = rsp_valid;
      lsu_rdata_o  = rsp_beat.data;
      lsu_rresp_o  = rsp_beat.resp;
    end else begin
      icache_rvalid_o = rsp_valid;
      icache_rdata_o  = rsp_beat.data;
      icache_rresp_o  = rsp_beat.resp;
    end
  end

  // State registers; reset abandons any transaction and makes icache win
  // the first tie by pretending lsu was granted last
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_ICACHE;
      last_grant_q <= OWNER_LSU;
      addr_q       <= '0;
      tmo_cnt_q    <= '0;
      late_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      late_seen_q  <= late_seen_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter. Stimulus processes act
// as the two masters and the memory; the memory pushes each expected response
// into the owning master's queue when it accepts an address, and monitors
// compare at the falling edge against a transaction-level model.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int TIMEOUT     = 8;
  localparam int RAND_CYCLES = 3000;

  logic        clock;
  logic        reset;
  logic        icache_arvalid_i, icache_arready_o, icache_rvalid_o, icache_rready_i;
  logic [31:0] icache_araddr_i, icache_rdata_o;
  logic [1:0]  icache_rresp_o;
  logic        lsu_arvalid_i, lsu_arready_o, lsu_rvalid_o, lsu_rready_i;
  logic [31:0] lsu_araddr_i, lsu_rdata_o;
  logic [1:0]  lsu_rresp_o;
  logic        mem_arvalid_o, mem_arready_i, mem_rvalid_i, mem_rready_o, busy_o;
  logic [31:0] mem_araddr_o, mem_rdata_i;
  logic [1:0]  mem_rresp_i;

  axi_rd_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock            (clock),
    .reset            (reset),
    .icache_arvalid_i (icache_arvalid_i),
    .icache_araddr_i  (icache_araddr_i),
    .icache_arready_o (icache_arready_o),
    .icache_rvalid_o  (icache_rvalid_o),
    .icache_rdata_o   (icache_rdata_o),
    .icache_rresp_o   (icache_rresp_o),
    .icache_rready_i  (icache_rready_i),
    .lsu_arvalid_i    (lsu_arvalid_i),
    .lsu_araddr_i     (lsu_araddr_i),
    .lsu_arready_o    (lsu_arready_o),
    .lsu_rvalid_o     (lsu_rvalid_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_rresp_o      (lsu_rresp_o),
    .lsu_rready_i     (lsu_rready_i),
    .mem_arvalid_o    (mem_arvalid_o),
    .mem_araddr_o     (mem_araddr_o),
    .mem_arready_i    (mem_arready_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rresp_i      (mem_rresp_i),
    .mem_rready_o     (mem_rready_o),
    .busy_o           (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Expected {data, resp} per master, in issue order
  logic [33:0] exp_ic_q[$];
  logic [33:0] exp_lsu_q[$];

  // Transaction-level model, owned by the model monitor
  bit          in_flight, ar_done, master_done, mem_done, timed_out;
  bit          model_last;
  bit          cur_owner;
  logic [31:0] cur_addr;
  int          data_cycles;

  // Handshakes the DUT sees at the coming rising edge, for the stimulus side
  bit ar_hs_ic, ar_hs_lsu, mem_ar_hs, mem_r_hs;

  // Stimulus-side state
  logic [31:0] req_addr [2];
  int          mem_phase, mem_cnt, mem_lat, lat_override;
  logic [33:0] mem_beat;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pickLatency();
    case ($urandom_range(0, 7))
      0:       return 1;
      1:       return 2;
      2:       return TIMEOUT - 1;
      3:       return TIMEOUT;
      4:       return TIMEOUT + 1;
      5:       return TIMEOUT + 4;
      default: return $urandom_range(1, TIMEOUT + 10);
    endcase
  endfunction

  // One cycle of master and memory behaviour, driven just after the rising edge
  task automatic applyStimulus(input bit allow_new);
    if (ar_hs_ic)  icache_arvalid_i = 1'b0;
    if (ar_hs_lsu) lsu_arvalid_i    = 1'b0;
    if (allow_new && !icache_arvalid_i && $urandom_range(0, 3) == 0) begin
      req_addr[0] = $urandom;
      icache_arvalid_i = 1'b1;
      icache_araddr_i  = req_addr[0];
    end
    if (allow_new && !lsu_arvalid_i && $urandom_range(0, 3) == 0) begin
      req_addr[1] = $urandom;
      lsu_arvalid_i = 1'b1;
      lsu_araddr_i  = req_addr[1];
    end
    icache_rready_i = ($urandom_range(0, 9) < 6);
    lsu_rready_i    = ($urandom_range(0, 9) < 6);

    if (mem_phase == 2 && mem_r_hs) begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_rresp_i  = '0;
      mem_phase    = 0;
    end else if (mem_phase == 0 && mem_ar_hs) begin
      mem_phase = 1;
      mem_cnt   = 0;
      mem_lat   = (lat_override != 0) ? lat_override : pickLatency();
      mem_beat  = {32'($urandom), 2'($urandom_range(0, 3))};
      if (mem_lat <= TIMEOUT) begin
        if (cur_owner) exp_lsu_q.push_back(mem_beat);
        else           exp_ic_q.push_back(mem_beat);
      end else begin
        if (cur_owner) exp_lsu_q.push_back({32'h0, RESP_DECERR});
        else           exp_ic_q.push_back({32'h0, RESP_DECERR});
      end
    end
    if (mem_phase == 1) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_beat[33:2];
        mem_rresp_i  = mem_beat[1:0];
        mem_phase    = 2;
      end
    end
    mem_arready_i = (mem_phase == 0) && ($urandom_range(0, 2) == 0);
  endtask

  // Model monitor: per-cycle protocol expectations, then advance the model
  always @(negedge clock) begin
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    logic       exp_mem_rready;
    logic       owner_rr;
    logic       data_phase;
    if (!reset) begin
      checkOutput("reset_outputs",
                  {icache_arready_o, icache_rvalid_o, icache_rdata_o, icache_rresp_o,
                   lsu_arready_o, lsu_rvalid_o, lsu_rdata_o, lsu_rresp_o,
                   mem_arvalid_o, mem_araddr_o, mem_rready_o, busy_o}, '0);
      in_flight = 0; ar_done = 0; master_done = 0; mem_done = 0; timed_out = 0;
      model_last = 1'b1; data_cycles = 0;
      ar_hs_ic = 0; ar_hs_lsu = 0; mem_ar_hs = 0; mem_r_hs = 0;
      exp_ic_q.delete();
      exp_lsu_q.delete();
    end else begin
      exp_gnt = 2'b00;
      if (!in_flight) begin
        if (icache_arvalid_i && lsu_arvalid_i) exp_gnt = model_last ? 2'b01 : 2'b10;
        else                                   exp_gnt = {lsu_arvalid_i, icache_arvalid_i};
      end
      checkOutput("arready", {lsu_arready_o, icache_arready_o}, exp_gnt);
      checkOutput("busy", busy_o, in_flight);
      checkOutput("mem_arvalid", mem_arvalid_o, in_flight && !ar_done);
      if (in_flight && !ar_done) checkOutput("mem_araddr", mem_araddr_o, cur_addr);

      owner_rr       = cur_owner ? lsu_rready_i : icache_rready_i;
      data_phase     = in_flight && ar_done && !master_done;
      exp_rv         = 2'b00;
      exp_mem_rready = 1'b0;
      if (data_phase) begin
        exp_rv[cur_owner] = timed_out ? 1'b1 : mem_rvalid_i;
        exp_mem_rready    = timed_out ? 1'b1 : owner_rr;
      end else if (in_flight && timed_out && !mem_done) begin
        exp_mem_rready = 1'b1;
      end
      checkOutput("rvalid", {lsu_rvalid_o, icache_rvalid_o}, exp_rv);
      checkOutput("mem_rready", mem_rready_o, exp_mem_rready);
      if (!(data_phase && cur_owner == 1'b0))
        checkOutput("icache_quiet", {icache_rvalid_o, icache_rdata_o, icache_rresp_o}, '0);
      if (!(data_phase && cur_owner == 1'b1))
        checkOutput("lsu_quiet", {lsu_rvalid_o, lsu_rdata_o, lsu_rresp_o}, '0);

      ar_hs_ic  = icache_arvalid_i && icache_arready_o;
      ar_hs_lsu = lsu_arvalid_i && lsu_arready_o;
      mem_ar_hs = mem_arvalid_o && mem_arready_i;
      mem_r_hs  = mem_rvalid_i && mem_rready_o;

      if (exp_gnt != 2'b00) begin
        in_flight = 1; ar_done = 0; master_done = 0; mem_done = 0; timed_out = 0;
        data_cycles = 0;
        cur_owner   = exp_gnt[1];
        cur_addr    = exp_gnt[1] ? req_addr[1] : req_addr[0];
        model_last  = exp_gnt[1];
      end else if (in_flight) begin
        if (!ar_done) begin
          if (mem_arready_i) ar_done = 1;
        end else begin
          if (!master_done && !timed_out) begin
            data_cycles++;
            if (!mem_rvalid_i && data_cycles == TIMEOUT) timed_out = 1;
          end
          if (exp_rv[cur_owner] && owner_rr) master_done = 1;
          if (mem_rvalid_i && exp_mem_rready) mem_done = 1;
          if (master_done && mem_done) in_flight = 0;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted response beat is matched in order
  always @(negedge clock) begin
    logic [33:0] want;
    if (reset) begin
      if (icache_rvalid_o && icache_rready_i) begin
        if (exp_ic_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL icache_beat actual=0x%0h required=no beat", {icache_rdata_o, icache_rresp_o});
        end else begin
          want = exp_ic_q.pop_front();
          checkOutput("icache_beat", {icache_rdata_o, icache_rresp_o}, want);
        end
      end
      if (lsu_rvalid_o && lsu_rready_i) begin
        if (exp_lsu_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL lsu_beat actual=0x%0h required=no beat", {lsu_rdata_o, lsu_rresp_o});
        end else begin
          want = exp_lsu_q.pop_front();
          checkOutput("lsu_beat", {lsu_rdata_o, lsu_rresp_o}, want);
        end
      end
    end
  end

  task automatic drainAll(input string name);
    int guard = 0;
    while ((in_flight || icache_arvalid_i || lsu_arvalid_i) && guard < 300) begin
      @(posedge clock); #1;
      applyStimulus(1'b0);
      guard++;
    end
    checkOutput({name, "_drained"}, guard >= 300, 1'b0);
    checkOutput({name, "_scoreboard_empty"}, exp_ic_q.size() + exp_lsu_q.size(), 0);
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    icache_arvalid_i = 1'b1; icache_araddr_i = 32'h100; icache_rready_i = 1'b0;
    lsu_arvalid_i    = 1'b1; lsu_araddr_i    = 32'h200; lsu_rready_i    = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rresp_i = '0;
    req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    mem_phase = 0; mem_cnt = 0; mem_lat = 0; lat_override = 0; mem_beat = '0;

    // Tie right after reset: icache must win, then alternation follows
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      @(posedge clock); #1;
      applyStimulus(1'b1);
    end
    drainAll("random");

    // Park a request deep in the data phase, then pull reset asynchronously
    lat_override = 1000;
    req_addr[0] = 32'h3000_0040;
    icache_araddr_i  = req_addr[0];
    icache_arvalid_i = 1'b1;
    guard = 0;
    while (!(in_flight && ar_done) && guard < 100) begin
      @(posedge clock); #1;
      applyStimulus(1'b0);
      guard++;
    end
    checkOutput("reach_data", guard >= 100, 1'b0);
    repeat (2) begin
      @(posedge clock); #1;
      applyStimulus(1'b0);
    end
    @(posedge clock); #3;
    reset = 1'b0;
    icache_arvalid_i = 1'b1; lsu_arvalid_i = 1'b1;
    req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    icache_araddr_i = req_addr[0]; lsu_araddr_i = req_addr[1];
    mem_rvalid_i = 1'b0; mem_arready_i = 1'b0; mem_phase = 0; lat_override = 0;
    #1;
    checkOutput("async_reset_outputs",
                {icache_arready_o, icache_rvalid_o, icache_rdata_o, icache_rresp_o,
                 lsu_arready_o, lsu_rvalid_o, lsu_rdata_o, lsu_rresp_o,
                 mem_arvalid_o, mem_araddr_o, mem_rready_o, busy_o}, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      applyStimulus(1'b1);
    end
    drainAll("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

- Two-master, single-slave read-channel arbiter placed between the instruction cache miss port and the LSU load port on one side and the shared memory AR/R bus on the other.
- Accepts one single-beat read at a time.
- Grants round-robin on contention and routes the R response back to the owning master.
- Synthesizes a DECERR response if memory does not answer within a bounded time, so a hung slave cannot wedge the fetch or load path.

## Interface

Parameters:
- `TIMEOUT`, default 1024: cycles in DATA before a synthesized error; 0 disables the watchdog.

Ports (`x` = `icache` | `lsu`):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `x_arvalid_i`  in  1  master read request.
- `x_araddr_i`  in  32  master read address.
- `x_arready_o`  out  1  request accepted this cycle.
- `x_rvalid_o`  out  1  response valid to master.
- `x_rdata_o`  out  32  response data.
- `x_rresp_o`  out  2  response code.
- `x_rready_i`  in  1  master accepts response.
- `mem_arvalid_o`  out  1  downstream request.
- `mem_araddr_o`  out  32  downstream address.
- `mem_arready_i`  in  1  downstream accepts address.
- `mem_rvalid_i`  in  1  downstream response valid.
- `mem_rdata_i`  in  32  downstream data.
- `mem_rresp_i`  in  2  downstream response code.
- `mem_rready_o`  out  1  arbiter accepts downstream response.
- `busy_o`  out  1  state != IDLE.

## Operation

- States: IDLE, ADDR, DATA, ERR, DRAIN. Registers:
  - `owner`: 0 = icache, 1 = lsu.
  - `last_grant`
  - `addr_q`
  - `tmo_cnt`: width `$clog2(TIMEOUT+1)`.
  - `late_seen`
- IDLE, arbitration:
  - Only one `arvalid` high → grant it.
  - Both high → grant the master that is not `last_grant`.
  - On grant:
    - Winner's `arready_o` = 1 combinationally.
    - Latch `addr_q`, `owner`, `last_grant`.
    - Next state is ADDR.
  - Loser sees `arready_o` = 0 and must keep `arvalid` held.
- ADDR:
  - `mem_arvalid_o` = 1, `mem_araddr_o` = `addr_q`.
  - On `mem_arready_i` → DATA and clear `tmo_cnt`.
  - No timeout in ADDR, so AR is never withdrawn.
- DATA:
  - Owner's `rvalid_o`/`rdata_o`/`rresp_o` mirror `mem_*`.
  - `mem_rready_o` = owner's `rready_i`.
  - Non-owner outputs are 0.
  - On `mem_rvalid_i` && owner `rready_i` → IDLE.
  - Otherwise `tmo_cnt` increments. When `TIMEOUT` != 0 and `tmo_cnt` == `TIMEOUT`-1 with no `mem_rvalid_i`, go to ERR with `late_seen` = 0.
  - `mem_rvalid_i` in the expiring cycle has priority over the timeout.
- ERR:
  - Owner sees `rvalid_o` = 1, `rresp_o` = 2'b11, `rdata_o` = 0.
  - `mem_rready_o` = 1 to absorb a late response; set `late_seen` on `mem_rvalid_i`.
  - On owner `rready_i`: go to IDLE if `late_seen` or `mem_rvalid_i` this cycle, else DRAIN.
- DRAIN:
  - `mem_rready_o` = 1, no master outputs.
  - On `mem_rvalid_i` → IDLE.
- `rresp` codes pass through unmodified; SLVERR/DECERR from memory are not reinterpreted.

## Timing

- Reset (async assert):
  - state = IDLE, `last_grant` = lsu (so icache wins the first tie).
  - `owner` = 0, `addr_q` = 0, `tmo_cnt` = 0, `late_seen` = 0.
  - All outputs 0.
- Reset mid-transaction abandons it silently.
- Deassertion is synchronized externally.
- Latency:
  - Grant to `mem_arvalid_o` is 1 cycle.
  - Best-case request-to-data is 3 cycles (IDLE grant, ADDR with immediate `arready`, DATA with immediate `rvalid`).
- Back-to-back: a new grant is possible in the IDLE cycle directly after the R handshake, so the minimum issue interval is 3 cycles.
- `x_arready_o` is never asserted outside IDLE, and never to both masters in the same cycle.
- `mem_rready_o` is 0 in IDLE and ADDR.

## Structure

- Shared package/header holds:
  - Response constants `RESP_OKAY` 2'b00, `RESP_EXOKAY` 2'b01, `RESP_SLVERR` 2'b10, `RESP_DECERR` 2'b11 (shared with the icache and LSU).
  - State encoding localparams.
- Sub-module `rr_pick2`: combinational two-request round-robin picker. Inputs `req[1:0]`, `last`; outputs `gnt[1:0]` (one-hot or zero).

## Test plan

- Icache only:
  - Stimulus: icache requests 0x3000_0040; mem `arready` on the 1st ADDR cycle; `rvalid` in DATA with data 0xDEAD_BEEF, resp 00.
  - Required: `icache_rvalid_o` carries 0xDEAD_BEEF 3 cycles after request; lsu outputs stay 0.
- Simultaneous requests right after reset:
  - Stimulus: icache 0x100 and lsu 0x200 request together; both held.
  - Required: icache is granted first, lsu second; then a repeat tie grants icache again (alternation).
- Backpressure:
  - Stimulus: `mem_arready_i` low for 5 cycles, then `rvalid` held while lsu `rready` is low for 2 cycles.
  - Required: AR and R stay stable; the handshake completes; state returns to IDLE.
- Timeout:
  - Stimulus: `TIMEOUT`=8; mem never responds; later mem `rvalid` arrives 4 cycles after ERR exit.
  - Required: owner gets resp 2'b11, data 0 after 8 DATA cycles; DRAIN absorbs the late beat; no stray `rvalid` to either master.
- Expiry race:
  - Stimulus: `mem_rvalid_i` arrives exactly in the expiry cycle.
  - Required: the real data with resp 00 is delivered and there is no ERR.
- Reset in DATA:
  - Stimulus: assert reset while in DATA.
  - Required: all outputs drop to 0 the same cycle; after release, the next tie grants icache.
